lane_demux_deser: RTL and testbench
===================================

Name: lane_demux_deser

Overview:
- Receive-side counterpart of the 4:1 lane selector.
- Takes a time-multiplexed stream, one lane value per accepted beat in lane order 00,01,10,11, and rebuilds the 4-lane frame.
- Presents the rebuilt frame as four registered outputs, using a valid/ready handshake on both sides.
- Sits at the far end of a serialised link, directly before parallel consumers.

Parameters:
- WIDTH, 1, bit width of each lane value (x0..x3 / din).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- din  input  WIDTH  lane value of the current beat.
- din_valid  input  1  beat present on din.
- din_sync  input  1  qualifies the current beat as lane 0 (frame start).
- din_ready  output  1  block can accept a beat this cycle.
- y0  output  WIDTH  rebuilt lane 0.
- y1  output  WIDTH  rebuilt lane 1.
- y2  output  WIDTH  rebuilt lane 2.
- y3  output  WIDTH  rebuilt lane 3.
- frame_valid  output  1  y0..y3 hold a complete frame.
- frame_ready  input  1  consumer takes the frame this cycle.
- sel_o  output  2  lane index the next accepted beat is written to.
- sync_err  output  1  one-cycle pulse: sync arrived mid-frame.

Behaviour:
- Accepted beat: din_valid && din_ready. Frame drain: frame_valid && frame_ready.
- Lane counter sel_cnt (2 bits) is the state: LANE0 -> LANE1 -> LANE2 -> LANE3 -> LANE0.
  - Advances only on an accepted beat.
  - Wraps 3 -> 0.
  - sel_o = sel_cnt.
- Capture:
  - Accepted beat in LANE0..LANE2 writes din into shadow[sel_cnt].
  - Accepted beat in LANE3 loads y0..y2 from shadow[0..2] and y3 from din, all in the same edge. frame_valid = 1 the next cycle.
  - Latency: lane-3 beat accepted in cycle N -> frame_valid high in cycle N+1.
- Output register:
  - y0..y3 and frame_valid hold until drained.
  - On drain without a new load, frame_valid clears next cycle. y values are held (don't-care while frame_valid = 0).
  - Drain and lane-3 load in the same cycle: y reloaded, frame_valid stays 1, no bubble.
- din_ready = (sel_cnt != 3) || !frame_valid || frame_ready. It is combinational and does not depend on din_valid or din_sync.
  - Lanes 0..2 are always accepted.
  - Only the completing beat stalls.
- Sync handling (applies to an accepted beat with din_sync = 1):
  - The beat is written to shadow[0] and sel_cnt becomes 1, regardless of the current sel_cnt.
  - If sel_cnt != 0, the partial frame is discarded (no output load) and sync_err pulses high for the next cycle only.
  - If sel_cnt == 0, no error is reported.
  - A sync beat in LANE3 never loads the output, even though din_ready was computed for a lane-3 beat.
  - din_sync without din_valid, or while din_ready = 0, is ignored.
- Reset (synchronous, any state including mid-frame or with frame pending): next cycle sel_cnt = 0, shadow = 0, y0..y3 = 0, frame_valid = 0, sync_err = 0. Any partial or pending frame is lost.
- No arithmetic beyond the 2-bit wrapping increment. Lane data passes through unmodified, full WIDTH.

Decomposition:
- Shared package lane_pkg:
  - N_LANES = 4, SEL_W = 2.
  - Lane index constants LANE0 = 2'b00, LANE1 = 2'b01, LANE2 = 2'b10, LANE3 = 2'b11. These are the same encoding the transmit-side selector uses, and both sides import them.
- One natural sub-module: frame_out_reg.
  - 4×WIDTH output holding register with frame_valid/frame_ready.
  - Exposes load and accept-permitted signals.
- The top block keeps the counter, shadow registers, sync logic and din_ready.

Test Plan:
- Reset, WIDTH = 1, frame_ready = 1; beats 1 (sync), 0, 1, 1 on consecutive cycles -> cycle after 4th beat: y0 = 1, y1 = 0, y2 = 1, y3 = 1, frame_valid = 1 for exactly 1 cycle; sync_err never 1.
- Backpressure: frame_ready = 0 after frame A, send frame B -> B lanes 0..2 accepted (sel_o = 3), din_ready = 0, A held stable. Raise frame_ready -> A drained, B lane 3 accepted same cycle, B visible next cycle, frame_valid never drops.
- Sync mid-frame: beats 1, 1 then sync beat 0 -> sync_err = 1 one cycle, sel_o = 1. Then 1, 0, 1 -> y = {0, 1, 0, 1} (y0..y3), no output from the aborted frame.
- Idle gaps: din_valid toggled 1, 0, 0, 1, 0, 1, 1 -> sel_o advances only on valid cycles; one frame out after 4th valid beat.
- Reset with sel_o = 2 and frame_valid = 1 -> next cycle sel_o = 0, frame_valid = 0, y0..y3 = 0. The following 4 beats form a fresh frame.
- Streaming WIDTH = 8, frame_ready = 1, 16 back-to-back beats 0x00..0x0F -> 4 frames {00, 01, 02, 03} ... {0C, 0D, 0E, 0F}, one every 4 cycles, din_ready constantly 1.

Source files
------------

// File: rtl/lane_pkg.sv
// Lane index encoding shared by the transmit-side selector and the receive-side
// demux/deserialiser, so both ends of the link agree on beat order.
package lane_pkg;

  localparam int N_LANES = 4;
  localparam int SEL_W   = 2;

  localparam logic [SEL_W-1:0] LANE0 = 2'b00;
  localparam logic [SEL_W-1:0] LANE1 = 2'b01;
  localparam logic [SEL_W-1:0] LANE2 = 2'b10;
  localparam logic [SEL_W-1:0] LANE3 = 2'b11;

endpackage

// File: rtl/lane_demux_deser_frame_out_reg.sv
// Four-lane output holding register: loads a whole frame at once and holds it
// with frame_valid until the consumer takes it.
module frame_out_reg
  import lane_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic [N_LANES-1:0][WIDTH-1:0]   ld_data,
  output logic                            accept_ok,
  output logic [WIDTH-1:0]                y0,
  output logic [WIDTH-1:0]                y1,
  output logic [WIDTH-1:0]                y2,
  output logic [WIDTH-1:0]                y3,
  output logic                            frame_valid,
  input  logic                            frame_ready
);

  logic [N_LANES-1:0][WIDTH-1:0] y_q, y_d;
  logic                          valid_q, valid_d;

  // A load in the same cycle as a drain wins, so back-to-back frames have no bubble.
  always_comb begin
    y_d     = y_q;
    valid_d = valid_q;
    if (load) begin
      y_d     = ld_data;
      valid_d = 1'b1;
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign accept_ok   = !valid_q || frame_ready;
  assign frame_valid = valid_q;
  assign y0          = y_q[0];
  assign y1          = y_q[1];
  assign y2          = y_q[2];
  assign y3          = y_q[3];

endmodule

// File: rtl/lane_demux_deser.sv
// Rebuilds 4-lane frames from a lane-serial beat stream; din_sync marks lane 0
// and realigns the lane counter, flagging any partial frame it cuts short.
module lane_demux_deser
  import lane_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             din_sync,
  output logic             din_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [SEL_W-1:0] sel_o,
  output logic             sync_err
);

  logic [SEL_W-1:0]              sel_q, sel_d;
  logic                          err_q, err_d;
  logic [N_LANES-2:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [N_LANES-2:0]            shadow_we;
  logic                          accept;
  logic                          load;
  logic                          accept_ok;
  logic [N_LANES-1:0][WIDTH-1:0] ld_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= LANE0;
      err_q    <= 1'b0;
      shadow_q <= '0;
    end else begin
      sel_q    <= sel_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
    end
  end

  // Next-state logic: a sync beat always restarts the frame at lane 1.
  always_comb begin
    sel_d = sel_q;
    err_d = 1'b0;
    if (accept) begin
      if (din_sync) begin
        sel_d = LANE1;
        err_d = (sel_q != LANE0);
      end else begin
        sel_d = sel_q + 2'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_LANES - 1; gi++) begin : g_shadow_we
      assign shadow_we[gi] = accept &&
                             (din_sync ? (gi == 0) : (sel_q == SEL_W'(gi)));
    end
  endgenerate

  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < N_LANES - 1; i++) begin
      if (shadow_we[i]) shadow_d[i] = din;
    end
  end

  // Output logic
  always_comb begin
    din_ready = (sel_q != LANE3) || accept_ok;
    accept    = din_valid && din_ready;
    load      = accept && !din_sync && (sel_q == LANE3);
    ld_data   = {din, shadow_q[2], shadow_q[1], shadow_q[0]};
  end

  assign sel_o    = sel_q;
  assign sync_err = err_q;

  frame_out_reg #(.WIDTH(WIDTH)) u_frame_out_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .ld_data     (ld_data),
    .accept_ok   (accept_ok),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
  );

endmodule

// File: tb/tb_lane_demux_deser.sv
// Directed bench: a WIDTH=1 instance for framing/handshake/sync cases and a
// WIDTH=8 instance for back-to-back streaming.
module tb_lane_demux_deser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // WIDTH = 1 instance
  logic       a_rst = 1'b1, a_din = 1'b0, a_valid = 1'b0, a_sync = 1'b0, a_fready = 1'b1;
  logic       a_dready, a_fvalid, a_serr;
  logic [0:0] a_y0, a_y1, a_y2, a_y3;
  logic [1:0] a_sel;

  lane_demux_deser #(.WIDTH(1)) dut_a (
    .clk(clk), .rst(a_rst), .din(a_din), .din_valid(a_valid), .din_sync(a_sync),
    .din_ready(a_dready), .y0(a_y0), .y1(a_y1), .y2(a_y2), .y3(a_y3),
    .frame_valid(a_fvalid), .frame_ready(a_fready), .sel_o(a_sel), .sync_err(a_serr)
  );

  // WIDTH = 8 instance
  logic       b_rst = 1'b1, b_valid = 1'b0, b_sync = 1'b0, b_fready = 1'b1;
  logic [7:0] b_din = 8'h00;
  logic       b_dready, b_fvalid, b_serr;
  logic [7:0] b_y0, b_y1, b_y2, b_y3;
  logic [1:0] b_sel;

  lane_demux_deser #(.WIDTH(8)) dut_b (
    .clk(clk), .rst(b_rst), .din(b_din), .din_valid(b_valid), .din_sync(b_sync),
    .din_ready(b_dready), .y0(b_y0), .y1(b_y1), .y2(b_y2), .y3(b_y3),
    .frame_valid(b_fvalid), .frame_ready(b_fready), .sel_o(b_sel), .sync_err(b_serr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted-or-offered beat on instance A, then release din_valid.
  task automatic a_beat(input logic d, input logic s);
    a_din   = d;
    a_sync  = s;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    a_sync  = 1'b0;
  endtask

  task automatic a_y(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, a_y0, a_y1, a_y2, a_y3}, {28'd0, exp});
  endtask

  initial begin
    // Reset
    tick(); tick();
    a_rst = 1'b0;
    b_rst = 1'b0;
    chk("rst_sel", a_sel, 2'd0);
    chk("rst_fvalid", a_fvalid, 1'b0);
    a_y("rst_y", 4'b0000);
    chk("rst_serr", a_serr, 1'b0);
    chk("rst_dready", a_dready, 1'b1);
    $display("reset done");

    // Test 1: basic frame 1,0,1,1
    a_beat(1'b1, 1'b1); chk("t1_sel1", a_sel, 2'd1); chk("t1_serr1", a_serr, 1'b0);
    a_beat(1'b0, 1'b0); chk("t1_sel2", a_sel, 2'd2); chk("t1_serr2", a_serr, 1'b0);
    a_beat(1'b1, 1'b0); chk("t1_sel3", a_sel, 2'd3); chk("t1_fv_pre", a_fvalid, 1'b0);
    a_beat(1'b1, 1'b0); chk("t1_sel0", a_sel, 2'd0);
    chk("t1_fvalid", a_fvalid, 1'b1);
    a_y("t1_y", 4'b1011);
    chk("t1_serr4", a_serr, 1'b0);
    tick();
    chk("t1_fv_drop", a_fvalid, 1'b0);
    $display("t1 frame y=%b%b%b%b", a_y0, a_y1, a_y2, a_y3);

    // Test 2: backpressure, frame A = 0,1,1,0 held, frame B = 1,0,0,1
    a_fready = 1'b0;
    a_beat(1'b0, 1'b1); a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b0); a_beat(1'b0, 1'b0);
    chk("t2_a_fvalid", a_fvalid, 1'b1);
    a_y("t2_a_y", 4'b0110);
    a_beat(1'b1, 1'b1); a_beat(1'b0, 1'b0); a_beat(1'b0, 1'b0);
    chk("t2_sel3", a_sel, 2'd3);
    a_din = 1'b1; a_valid = 1'b1; #1;
    chk("t2_dready_low", a_dready, 1'b0);
    tick();
    chk("t2_stall_sel", a_sel, 2'd3);
    chk("t2_hold_fv", a_fvalid, 1'b1);
    a_y("t2_hold_y", 4'b0110);
    a_fready = 1'b1; #1;
    chk("t2_dready_high", a_dready, 1'b1);
    tick();
    a_valid = 1'b0;
    chk("t2_b_fvalid", a_fvalid, 1'b1);
    a_y("t2_b_y", 4'b1001);
    chk("t2_sel0", a_sel, 2'd0);
    tick();
    chk("t2_drain", a_fvalid, 1'b0);
    $display("t2 backpressure handoff done");

    // Test 3: sync mid-frame (sel=2), then a sync beat while in lane 3
    a_beat(1'b1, 1'b1); a_beat(1'b1, 1'b0);
    a_beat(1'b0, 1'b1);
    chk("t3_serr", a_serr, 1'b1);
    chk("t3_sel1", a_sel, 2'd1);
    chk("t3_fv", a_fvalid, 1'b0);
    a_beat(1'b1, 1'b0);
    chk("t3_serr_pulse", a_serr, 1'b0);
    a_beat(1'b0, 1'b0); a_beat(1'b1, 1'b0);
    chk("t3_fvalid", a_fvalid, 1'b1);
    a_y("t3_y", 4'b0101);
    tick();
    a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b0);
    a_beat(1'b1, 1'b1);
    chk("t3_l3_serr", a_serr, 1'b1);
    chk("t3_l3_noload", a_fvalid, 1'b0);
    chk("t3_l3_sel", a_sel, 2'd1);
    a_beat(1'b0, 1'b0); a_beat(1'b0, 1'b0); a_beat(1'b0, 1'b0);
    chk("t3_l3_fvalid", a_fvalid, 1'b1);
    a_y("t3_l3_y", 4'b1000);
    tick();
    $display("t3 sync handling done");

    // Test 4: idle gaps; invalid cycles carry junk din and din_sync
    begin
      logic [6:0] vpat = 7'b1001011;            // bit 6 first
      logic [3:0] dpat = 4'b0110;               // valid beats in order, bit 3 first
      logic [1:0] sexp [7] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
      int k = 3;
      for (int i = 0; i < 7; i++) begin
        a_valid = vpat[6-i];
        if (a_valid) begin a_din = dpat[k]; a_sync = 1'b0; k--; end
        else         begin a_din = 1'b1;   a_sync = 1'b1; end
        tick();
        chk($sformatf("t4_sel%0d", i), a_sel, sexp[i]);
        chk($sformatf("t4_fv%0d", i), a_fvalid, (i == 6) ? 1'b1 : 1'b0);
      end
      a_valid = 1'b0; a_sync = 1'b0;
      a_y("t4_y", 4'b0110);
      tick();
    end
    $display("t4 idle gaps done");

    // Test 5: reset with sel=2 and a pending frame
    a_fready = 1'b0;
    a_beat(1'b1, 1'b1); a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b0); a_beat(1'b1, 1'b0);
    a_beat(1'b1, 1'b1); a_beat(1'b1, 1'b0);
    chk("t5_pre_sel", a_sel, 2'd2);
    chk("t5_pre_fv", a_fvalid, 1'b1);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    a_fready = 1'b1;
    chk("t5_sel", a_sel, 2'd0);
    chk("t5_fv", a_fvalid, 1'b0);
    a_y("t5_y", 4'b0000);
    chk("t5_serr", a_serr, 1'b0);
    a_beat(1'b1, 1'b0); a_beat(1'b0, 1'b0); a_beat(1'b0, 1'b0); a_beat(1'b1, 1'b0);
    chk("t5_fresh_fv", a_fvalid, 1'b1);
    a_y("t5_fresh_y", 4'b1001);
    $display("t5 reset mid-frame done");

    // Test 6: WIDTH=8 streaming, 16 back-to-back beats
    b_fready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b_din   = 8'(i);
      b_sync  = (i % 4 == 0);
      b_valid = 1'b1;
      #1;
      chk($sformatf("t6_dready%0d", i), b_dready, 1'b1);
      tick();
      if (i % 4 == 3) begin
        chk($sformatf("t6_fv%0d", i), b_fvalid, 1'b1);
        chk($sformatf("t6_y%0d", i), {b_y0, b_y1, b_y2, b_y3},
            {8'(i - 3), 8'(i - 2), 8'(i - 1), 8'(i)});
        $display("t6 frame %0d y=%h %h %h %h", i / 4, b_y0, b_y1, b_y2, b_y3);
      end else begin
        chk($sformatf("t6_fv%0d", i), b_fvalid, 1'b0);
      end
      chk($sformatf("t6_serr%0d", i), b_serr, 1'b0);
    end
    b_valid = 1'b0;
    b_sync  = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
